// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, issues one request at a time, buffers {inst, pc} for decode.
// Latency: response -> o_inst_valid 1 cycle (0 cycles through the bypass path when IFETCH_BYPASS_EN is defined).
// Backpressure: requests stop while the buffer has no free slot; decode stalls via i_inst_ready.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_redirect, i_redirect_pc      one-cycle redirect pulse and new fetch PC (bits [1:0] ignored)
//   o_imem_req_valid/_addr,
//   i_imem_req_ready               instruction memory request channel (valid/ready)
//   i_imem_rsp_valid/_data         in-order responses, one per accepted request
//   o_inst_valid/o_inst/o_inst_pc,
//   i_inst_ready                   decode channel (valid/ready)
// Optional macro: IFETCH_BYPASS_EN drives the decode outputs straight from a response that
// arrives while the buffer is empty.
module ifetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          BUF_DEPTH  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic        o_inst_valid,
   input  logic        i_inst_ready,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t        r_state;
   logic [31:0]   r_fpc;
   logic [31:0]   r_req_pc;
   logic [31:0]   r_buf_inst [BUF_DEPTH];
   logic [31:0]   r_buf_pc   [BUF_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_fifo_empty;
   logic w_req_acc;
   logic w_rsp_take;
   logic w_push;
   logic w_pop;

   assign w_fifo_empty = (r_count == '0);

   // Only one request is ever outstanding, so a free slot at request time is
   // enough to hold its response. Gating with i_rst_n keeps valid low in reset.
   assign o_imem_req_valid = i_rst_n && (r_state == S_REQ) &&
                             (r_count < CW'(BUF_DEPTH)) && !i_redirect;
   assign o_imem_req_addr  = r_fpc;
   assign w_req_acc        = o_imem_req_valid && i_imem_req_ready;

   // A response is kept only when it belongs to a live request and no redirect
   // is flushing the stage in the same cycle.
   assign w_rsp_take = (r_state == S_WAIT) && i_imem_rsp_valid && !i_redirect;
   assign w_pop      = !w_fifo_empty && i_inst_ready;

`ifdef IFETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass     = w_rsp_take && w_fifo_empty;
   assign o_inst_valid = w_bypass || !w_fifo_empty;
   assign o_inst       = w_bypass ? i_imem_rsp_data : r_buf_inst[r_rd_ptr];
   assign o_inst_pc    = w_bypass ? r_req_pc        : r_buf_pc[r_rd_ptr];
   // A bypassed word taken by decode in the same cycle never enters the buffer.
   assign w_push       = w_rsp_take && !(w_bypass && i_inst_ready);
`else
   assign o_inst_valid = !w_fifo_empty;
   assign o_inst       = r_buf_inst[r_rd_ptr];
   assign o_inst_pc    = r_buf_pc[r_rd_ptr];
   assign w_push       = w_rsp_take;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_REQ;
         r_fpc    <= RESET_ADDR;
         r_req_pc <= RESET_ADDR;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf_inst[i] <= '0;
            r_buf_pc[i]   <= '0;
         end
      end else if (i_redirect) begin
         // Redirect wins over every other event this cycle.
         r_fpc    <= {i_redirect_pc[31:2], 2'b00};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         // A request still in flight must have its response thrown away later;
         // one arriving right now is simply dropped.
         r_state  <= ((r_state != S_REQ) && !i_imem_rsp_valid) ? S_DRAIN : S_REQ;
      end else begin
         if (w_req_acc) begin
            r_req_pc <= r_fpc;
            r_fpc    <= r_fpc + 32'd4;
         end

         if (w_push) begin
            r_buf_inst[r_wr_ptr] <= i_imem_rsp_data;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         case (r_state)
            S_REQ:   if (w_req_acc)        r_state <= S_WAIT;
            S_WAIT:  if (i_imem_rsp_valid) r_state <= S_REQ;
            S_DRAIN: if (i_imem_rsp_valid) r_state <= S_REQ;
            default:                       r_state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

   localparam logic [31:0] RST_A = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;

   always #5 clk = ~clk;

   ifetch #(.RESET_ADDR(RST_A), .BUF_DEPTH(2)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_redirect       (i_redirect),
      .i_redirect_pc    (i_redirect_pc),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_inst_valid     (o_inst_valid),
      .i_inst_ready     (i_inst_ready),
      .o_inst           (o_inst),
      .o_inst_pc        (o_inst_pc)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic [31:0] start_pc;
      int          lat;
      int          rmode;     // decode ready: 0 always, 1 never, 2 random
      int          qmode;     // memory req ready: 0 always, 2 random
      int          n;
      logic [31:0] first_pc;
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 1, rmode = 0, qmode = 0;
   bit          mem_busy = 0, mem_stale = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   logic [31:0] exp_addr = RST_A;
   int          n_acc = 0, n_pop = 0;
   bit          lat_chk = 0, prev_rsp = 0, first_chk = 0;
   logic [31:0] first_pc = '0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, sample #1 later, the posedge then commits.
   task automatic cycle(input bit redir, input logic [31:0] rpc);
      bit rsp, live, acc, pop;
      exp_t e;
      @(negedge clk);
      rsp              = mem_busy && (mem_cnt == 0);
      live             = rsp && !mem_stale;
      i_redirect       = redir;
      i_redirect_pc    = rpc;
      i_imem_rsp_valid = rsp;
      i_imem_rsp_data  = rsp ? inst_of(mem_addr) : $urandom;
      i_inst_ready     = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      i_imem_req_ready = (qmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (redir) begin
         chk("req_vld_in_redirect", 32'(o_imem_req_valid), 32'd0);
         sb.delete();
         exp_addr = {rpc[31:2], 2'b00};
         if (mem_busy && !rsp) mem_stale = 1'b1;
      end
      if (lat_chk && !redir)
         chk("inst_vld_latency", 32'(o_inst_valid), 32'(BYP ? live : prev_rsp));
      pop = o_inst_valid && i_inst_ready && !redir;
      if (pop) begin
         n_pop++;
         chk("sb_nonempty_on_pop", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pop_inst", o_inst, e.inst);
            chk("pop_pc", o_inst_pc, e.pc);
            if (first_chk) begin
               chk("first_pc", o_inst_pc, first_pc);
               first_chk = 1'b0;
            end
         end
      end
      acc = o_imem_req_valid && i_imem_req_ready;
      if (rsp) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (acc) begin
         n_acc++;
         chk("req_addr", o_imem_req_addr, exp_addr);
         e.inst = inst_of(exp_addr);
         e.pc   = exp_addr;
         sb.push_back(e);
         mem_busy  = 1'b1;
         mem_stale = 1'b0;
         mem_cnt   = lat - 1;
         mem_addr  = exp_addr;
         exp_addr  = exp_addr + 32'd4;
      end
      prev_rsp = live && !redir;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_redirect = 0; i_redirect_pc = '0; i_imem_req_ready = 0;
      i_imem_rsp_valid = 0; i_imem_rsp_data = '0; i_inst_ready = 0;
      sb.delete();
      mem_busy = 0; mem_stale = 0; prev_rsp = 0; exp_addr = RST_A;
      #1;
      chk("rst_req_vld", 32'(o_imem_req_valid), 32'd0);
      chk("rst_inst_vld", 32'(o_inst_valid), 32'd0);
      chk("rst_inst", o_inst, 32'd0);
      chk("rst_inst_pc", o_inst_pc, 32'd0);
      chk("rst_addr", o_imem_req_addr, RST_A);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_pops(input int target, input int budget);
      int start = n_pop;
      int c = 0;
      while ((n_pop - start) < target && c < budget) begin
         cycle(1'b0, '0);
         c++;
      end
      chk("pops_in_budget", 32'(n_pop - start), 32'(target));
   endtask

   task automatic run_accs(input int target, input int budget);
      int start = n_acc;
      int c = 0;
      while ((n_acc - start) < target && c < budget) begin
         cycle(1'b0, '0);
         c++;
      end
      chk("accs_in_budget", 32'(n_acc - start), 32'(target));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      int   a0;
      tbl[0] = '{32'h0000_1000, 1, 0, 0, 6, 32'h0000_1000};
      tbl[1] = '{32'h0000_2002, 2, 2, 2, 8, 32'h0000_2000};
      tbl[2] = '{32'h0000_3001, 3, 2, 0, 5, 32'h0000_3000};
      tbl[3] = '{32'hFFFF_FFF8, 1, 0, 2, 5, 32'hFFFF_FFF8};
      tbl[4] = '{32'h0000_0FFF, 2, 2, 2, 6, 32'h0000_0FFC};

      rst_n = 1'b0;
      i_redirect = 0; i_redirect_pc = '0; i_imem_req_ready = 0;
      i_imem_rsp_valid = 0; i_imem_rsp_data = '0; i_inst_ready = 0;
      do_reset();

      // Straight-line fetch from reset, latency of each instruction checked.
      lat = 1; rmode = 0; qmode = 0; lat_chk = 1;
      first_chk = 1; first_pc = RST_A;
      run_pops(3, 50);
      lat_chk = 0;

      // Decode stalled: buffer fills after two requests, then drains in order.
      do_reset();
      rmode = 1; a0 = n_acc;
      repeat (10) cycle(1'b0, '0);
      chk("acc_when_blocked", 32'(n_acc - a0), 32'd2);
      chk("req_vld_when_full", 32'(o_imem_req_valid), 32'd0);
      rmode = 0; first_chk = 1; first_pc = 32'h0;
      run_pops(3, 50);

      // Redirect while waiting on 0x8: its response must vanish.
      do_reset();
      lat = 3; rmode = 0;
      run_accs(3, 100);
      cycle(1'b1, 32'h100);
      cycle(1'b0, '0);
      chk("inst_vld_after_redir_wait", 32'(o_inst_valid), 32'd0);
      first_chk = 1; first_pc = 32'h100;
      run_pops(2, 100);

      // Redirect coinciding with a response and a pending pop.
      do_reset();
      lat = 1; rmode = 1;
      run_accs(2, 50);
      rmode = 0;
      cycle(1'b1, 32'h203);
      cycle(1'b0, '0);
      chk("inst_vld_after_redir_rsp", 32'(o_inst_valid), 32'd0);
      chk("addr_after_redir_rsp", o_imem_req_addr, 32'h200);
      first_chk = 1; first_pc = 32'h200;
      run_pops(2, 50);

      // Reset in the middle of a wait.
      do_reset();
      lat = 4;
      run_accs(1, 20);
      cycle(1'b0, '0);
      do_reset();
      lat = 1; first_chk = 1; first_pc = RST_A;
      run_pops(2, 50);

      // Empty buffer with a response at 0x40 (0xDEADBEEF): latency per build.
      lat = 1; rmode = 0; qmode = 0;
      cycle(1'b1, 32'h40);
      lat_chk = 1; first_chk = 1; first_pc = 32'h40;
      run_pops(3, 50);
      lat_chk = 0;

      // Table of redirect targets, latencies and handshake patterns.
      for (int i = 0; i < 5; i++) begin
         lat   = tbl[i].lat;
         rmode = tbl[i].rmode;
         qmode = tbl[i].qmode;
         cycle(1'b1, tbl[i].start_pc);
         first_chk = 1; first_pc = tbl[i].first_pc;
         run_pops(tbl[i].n, 400);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
